ow_read_engine: RTL and testbench

// - Parametrised 1-Wire read-slot engine: issues N_BITS consecutive read time slots and shifts in the returned bits LSB-first.
// - Computes the Dallas/Maxim CRC-8 over the received stream and reports pass/fail.
// - Used for ROM reads (64 bits) and scratchpad reads (72 bits); sits below the reset/presence and command-write engines in the 1-Wire master.

---
 rtl/ow_read_engine_pkg.sv | 33 +++
 rtl/ow_read_engine_if.sv | 21 ++
 rtl/ow_read_engine_crc8.sv | 27 ++
 rtl/ow_read_engine.sv | 134 +++++++++++++
 tb/tb_ow_read_engine.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ow_read_engine_pkg.sv
// Shared 1-Wire definitions: slot timing defaults per clock rate, FSM state type
// and the single-bit step of the reflected Dallas/Maxim CRC-8.
package ow_read_engine_pkg;

  localparam int OW_T_LOW_1MHZ     = 6;
  localparam int OW_T_SAMPLE_1MHZ  = 15;
  localparam int OW_T_SLOT_1MHZ    = 70;
  localparam int OW_T_LOW_10MHZ    = 60;
  localparam int OW_T_SAMPLE_10MHZ = 150;
  localparam int OW_T_SLOT_10MHZ   = 700;
  localparam int OW_T_LOW_50MHZ    = 300;
  localparam int OW_T_SAMPLE_50MHZ = 750;
  localparam int OW_T_SLOT_50MHZ   = 3500;

  localparam int OW_T_LOW    = OW_T_LOW_1MHZ;
  localparam int OW_T_SAMPLE = OW_T_SAMPLE_1MHZ;
  localparam int OW_T_SLOT   = OW_T_SLOT_1MHZ;

  localparam logic [7:0] OW_CRC_POLY = 8'h8C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    DONE = 2'd2
  } owState_t;

  function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    return (crc >> 1) ^ (fb ? OW_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ow_read_engine_if.sv
// Control/result bundle between a 1-Wire sequencer (master) and the read engine (slave).
interface ow_read_engine_if #(
  parameter int N_BITS = 64
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              crc_ok;
  logic [N_BITS-1:0] data;

  modport master (
    output start, abort,
    input  busy, done, crc_ok, data
  );

  modport slave (
    input  start, abort,
    output busy, done, crc_ok, data
  );
endinterface

// File: rtl/ow_read_engine_crc8.sv
// Serial CRC-8 (x^8+x^5+x^4+1, reflected) with synchronous clear and bit enable.
module ow_read_engine_crc8
  import ow_read_engine_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= 8'h00;
    end else if (i_clr) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= crc8Step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ow_read_engine.sv
// 1-Wire read-slot engine: issues N_BITS read slots, shifts the line in LSB-first
// and reports whether the received stream carries a valid CRC-8.
module ow_read_engine
  import ow_read_engine_pkg::*;
#(
  parameter int N_BITS    = 64,
  parameter int T_LOW     = OW_T_LOW,
  parameter int T_SAMPLE  = OW_T_SAMPLE,
  parameter int T_SLOT    = OW_T_SLOT,
  parameter int CHECK_CRC = 1
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire              io_bus,
  ow_read_engine_if.slave  ifc
);

  localparam int CNT_W = $clog2(T_SLOT);
  localparam int IDX_W = $clog2(N_BITS + 1);

  if (N_BITS < 1 || N_BITS > 1024 || T_LOW < 1 || T_SAMPLE < T_LOW + 2 ||
      T_SLOT <= T_SAMPLE || (CHECK_CRC != 0 && CHECK_CRC != 1)) begin : g_badParams
    $error("ow_read_engine: illegal parameter set");
  end

  owState_t          r_state;
  owState_t          w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cntNext;
  logic [IDX_W-1:0]  r_idx;
  logic [N_BITS-1:0] r_data;
  logic              r_driveLow;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_crcOk;
  logic [7:0]        w_crc;
  logic              w_lastCnt;
  logic              w_lastSlot;
  logic              w_sampleNow;
  logic              w_startNow;
  logic              w_busyOut;
  logic              w_doneOut;

  // Open-drain: the line is only ever pulled low or released.
  assign io_bus = r_driveLow ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= io_bus;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lastCnt   = (r_cnt == CNT_W'(T_SLOT - 1));
  assign w_lastSlot  = (r_idx == IDX_W'(N_BITS - 1));
  assign w_sampleNow = (r_state == SLOT) && (r_cnt == CNT_W'(T_SAMPLE));
  assign w_startNow  = (r_state == IDLE) && ifc.start && !ifc.abort;
  assign w_cntNext   = w_lastCnt ? '0 : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startNow) w_nextState = SLOT;
      SLOT: begin
        if (ifc.abort)                    w_nextState = IDLE;
        else if (w_lastCnt && w_lastSlot) w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_busyOut = 1'b0;
    w_doneOut = 1'b0;
    case (r_state)
      SLOT:    w_busyOut = 1'b1;
      DONE:    w_doneOut = 1'b1;
      default: ;
    endcase
  end

  // The drive enable is registered from the next count so the low phase lines up with cnt 0..T_LOW-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_driveLow <= 1'b0;
      r_crcOk    <= 1'b0;
    end else if (w_startNow) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_driveLow <= 1'b1;
    end else if (r_state == SLOT && !ifc.abort) begin
      r_cnt      <= w_cntNext;
      r_driveLow <= (w_cntNext < CNT_W'(T_LOW)) && !(w_lastCnt && w_lastSlot);
      if (w_lastCnt && !w_lastSlot) r_idx <= r_idx + 1'b1;
      if (w_lastCnt && w_lastSlot)  r_crcOk <= (w_crc == 8'h00);
      for (int i = 0; i < N_BITS; i++) begin
        if (w_sampleNow && r_idx == IDX_W'(i)) r_data[i] <= r_sync2;
      end
    end else begin
      r_driveLow <= 1'b0;
    end
  end

  ow_read_engine_crc8 u_crc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_startNow),
    .i_en  (w_sampleNow),
    .i_bit (r_sync2),
    .o_crc (w_crc)
  );

  assign ifc.busy   = w_busyOut;
  assign ifc.done   = w_doneOut;
  assign ifc.data   = r_data;
  assign ifc.crc_ok = (CHECK_CRC != 0) ? r_crcOk : 1'b1;

endmodule

// File: tb/tb_ow_read_engine.sv
// Scoreboard bench for ow_read_engine: a 64-bit and an 8-bit instance, each with a
// behavioural 1-Wire slave that answers read slots from a preset bit pattern.
module tb_ow_read_engine;

  typedef struct {
    logic [63:0] data;
    logic        crcOk;
    int          doneEdge;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst64;
  logic rst8;
  wire  busLine64;
  wire  busLine8;
  logic slaveLow64 = 1'b0;
  logic slaveLow8  = 1'b0;
  bit   armed64    = 1'b0;
  bit   armed8     = 1'b0;
  logic [63:0] slaveBits64 = '1;
  logic [7:0]  slaveBits8  = '1;
  int   slotIdx64 = 0;
  int   slotIdx8  = 0;
  int   cycleCount = 0;
  int   errors = 0;
  int   checks = 0;
  int   doneCount64 = 0;
  int   doneCount8 = 0;
  exp_t q64[$];
  exp_t q8[$];

  ow_read_engine_if #(.N_BITS(64)) ifc64 ();
  ow_read_engine_if #(.N_BITS(8))  ifc8 ();

  pullup (busLine64);
  pullup (busLine8);
  assign busLine64 = slaveLow64 ? 1'b0 : 1'bz;
  assign busLine8  = slaveLow8  ? 1'b0 : 1'bz;

  ow_read_engine #(
    .N_BITS(64), .T_LOW(6), .T_SAMPLE(15), .T_SLOT(70), .CHECK_CRC(1)
  ) dut64 (
    .clk    (clk),
    .rst    (rst64),
    .io_bus (busLine64),
    .ifc    (ifc64)
  );

  ow_read_engine #(
    .N_BITS(8), .T_LOW(6), .T_SAMPLE(15), .T_SLOT(70), .CHECK_CRC(1)
  ) dut8 (
    .clk    (clk),
    .rst    (rst8),
    .io_bus (busLine8),
    .ifc    (ifc8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Slave: after the master's falling edge, hold the line low 30 cycles for a 0 bit.
  always begin
    @(negedge busLine64);
    if (armed64 && !slaveLow64) begin
      if (slotIdx64 < 64 && slaveBits64[slotIdx64[5:0]] == 1'b0) begin
        slaveLow64 = 1'b1;
        repeat (30) @(posedge clk);
        slaveLow64 = 1'b0;
      end
      slotIdx64++;
    end
  end

  always begin
    @(negedge busLine8);
    if (armed8 && !slaveLow8) begin
      if (slotIdx8 < 8 && slaveBits8[slotIdx8[2:0]] == 1'b0) begin
        slaveLow8 = 1'b1;
        repeat (30) @(posedge clk);
        slaveLow8 = 1'b0;
      end
      slotIdx8++;
    end
  end

  function automatic logic crcOkOf(input logic [63:0] bits, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = c[0] ^ bits[i];
      c  = (c >> 1) ^ (fb ? 8'h8C : 8'h00);
    end
    return (c == 8'h00);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue a start on one instance and queue the response it must produce.
  task automatic applyStimulus(input bit use8, input logic [63:0] bits, input logic expCrc,
                               input string name);
    exp_t e;
    e.data     = use8 ? {56'h0, bits[7:0]} : bits;
    e.crcOk    = expCrc;
    e.name     = name;
    e.doneEdge = cycleCount + 1 + (use8 ? 8 : 64) * 70;
    if (use8) begin
      slaveBits8 = bits[7:0];
      slotIdx8   = 0;
      armed8     = 1'b1;
      q8.push_back(e);
      ifc8.start = 1'b1;
    end else begin
      slaveBits64 = bits;
      slotIdx64   = 0;
      armed64     = 1'b1;
      q64.push_back(e);
      ifc64.start = 1'b1;
    end
    @(negedge clk);
    ifc8.start  = 1'b0;
    ifc64.start = 1'b0;
  endtask

  task automatic waitDrain(input bit use8, input string name, input logic expCrc);
    int n;
    n = 0;
    while ((use8 ? q8.size() : q64.size()) != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, ".completed"}, 64'(use8 ? q8.size() : q64.size()), 64'h0);
    q8.delete();
    q64.delete();
    @(negedge clk);
    checkOutput({name, ".donePulse"}, 64'(use8 ? ifc8.done : ifc64.done), 64'h0);
    checkOutput({name, ".busyAfter"}, 64'(use8 ? ifc8.busy : ifc64.busy), 64'h0);
    checkOutput({name, ".crcHeld"}, 64'(use8 ? ifc8.crc_ok : ifc64.crc_ok), 64'(expCrc));
  endtask

  always @(negedge clk) begin
    if (ifc64.done) begin : pop64
      exp_t e;
      doneCount64++;
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone64: got done=1, expected done=0");
      end else begin
        e = q64.pop_front();
        checkOutput({e.name, ".data"}, ifc64.data, e.data);
        checkOutput({e.name, ".crc_ok"}, 64'(ifc64.crc_ok), 64'(e.crcOk));
        checkOutput({e.name, ".latency"}, 64'(cycleCount), 64'(e.doneEdge));
      end
    end
    if (ifc8.done) begin : pop8
      exp_t e;
      doneCount8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone8: got done=1, expected done=0");
      end else begin
        e = q8.pop_front();
        checkOutput({e.name, ".data"}, 64'(ifc8.data), e.data);
        checkOutput({e.name, ".crc_ok"}, 64'(ifc8.crc_ok), 64'(e.crcOk));
        checkOutput({e.name, ".latency"}, 64'(cycleCount), 64'(e.doneEdge));
      end
    end
  end

  initial begin : stimulus
    int mism;
    int doneSnap;
    logic expLow;
    rst64 = 1'b1;
    rst8  = 1'b1;
    ifc64.start = 1'b0;
    ifc64.abort = 1'b0;
    ifc8.start  = 1'b0;
    ifc8.abort  = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset.bus64", 64'(busLine64), 64'h1);
    checkOutput("reset.busy64", 64'(ifc64.busy), 64'h0);
    checkOutput("reset.done64", 64'(ifc64.done), 64'h0);
    checkOutput("reset.crc64", 64'(ifc64.crc_ok), 64'h0);
    checkOutput("reset.data64", ifc64.data, 64'h0);
    checkOutput("reset.data8", 64'(ifc8.data), 64'h0);

    rst64 = 1'b0;
    rst8  = 1'b0;
    repeat (2) @(negedge clk);

    // All ones: also verify the 6-cycle low phase and 70-cycle slot period.
    applyStimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, crcOkOf(64'hFFFF_FFFF_FFFF_FFFF, 64), "ones");
    mism = 0;
    for (int i = 0; i < 140; i++) begin
      expLow = ((i % 70) < 6);
      if ((!busLine64) !== expLow) mism++;
      @(negedge clk);
    end
    checkOutput("ones.lowPhase", 64'(mism), 64'h0);
    checkOutput("ones.busyMid", 64'(ifc64.busy), 64'h1);
    waitDrain(1'b0, "ones", crcOkOf(64'hFFFF_FFFF_FFFF_FFFF, 64));

    applyStimulus(1'b0, 64'h0, 1'b1, "zeros");
    waitDrain(1'b0, "zeros", 1'b1);

    // A stray start mid-transaction must not disturb the running read.
    applyStimulus(1'b0, 64'hA200_0000_01B8_1C02, 1'b1, "rom");
    repeat (100) @(negedge clk);
    ifc64.start = 1'b1;
    @(negedge clk);
    ifc64.start = 1'b0;
    waitDrain(1'b0, "rom", 1'b1);

    applyStimulus(1'b0, 64'hA200_0000_01BA_1C02, 1'b0, "romBad");
    waitDrain(1'b0, "romBad", 1'b0);

    // Abort in slot 10 at cnt 3.
    slaveBits64 = '1;
    slotIdx64   = 0;
    ifc64.start = 1'b1;
    @(negedge clk);
    ifc64.start = 1'b0;
    repeat (703) @(negedge clk);
    checkOutput("abort.busLowBefore", 64'(busLine64), 64'h0);
    checkOutput("abort.busyBefore", 64'(ifc64.busy), 64'h1);
    ifc64.abort = 1'b1;
    @(negedge clk);
    ifc64.abort = 1'b0;
    checkOutput("abort.busReleased", 64'(busLine64), 64'h1);
    checkOutput("abort.busyAfter", 64'(ifc64.busy), 64'h0);
    doneSnap = doneCount64;
    repeat (150) @(negedge clk);
    checkOutput("abort.noDone", 64'(doneCount64), 64'(doneSnap));

    applyStimulus(1'b0, 64'hDEAD_BEEF_0123_4567, crcOkOf(64'hDEAD_BEEF_0123_4567, 64), "afterAbort");
    waitDrain(1'b0, "afterAbort", crcOkOf(64'hDEAD_BEEF_0123_4567, 64));

    // Start and abort together in IDLE: abort wins.
    ifc8.start = 1'b1;
    ifc8.abort = 1'b1;
    @(negedge clk);
    ifc8.start = 1'b0;
    ifc8.abort = 1'b0;
    checkOutput("startAbort.busy", 64'(ifc8.busy), 64'h0);
    checkOutput("startAbort.bus", 64'(busLine8), 64'h1);

    applyStimulus(1'b1, 64'h3C, crcOkOf(64'h3C, 8), "byte3C");
    waitDrain(1'b1, "byte3C", crcOkOf(64'h3C, 8));

    // Async reset while the engine is pulling the line low.
    slaveBits8 = '1;
    slotIdx8   = 0;
    ifc8.start = 1'b1;
    @(negedge clk);
    ifc8.start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midRst.busLowBefore", 64'(busLine8), 64'h0);
    @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    checkOutput("midRst.bus", 64'(busLine8), 64'h1);
    checkOutput("midRst.busy", 64'(ifc8.busy), 64'h0);
    checkOutput("midRst.done", 64'(ifc8.done), 64'h0);
    checkOutput("midRst.crc", 64'(ifc8.crc_ok), 64'h0);
    checkOutput("midRst.data", 64'(ifc8.data), 64'h0);
    @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 64'hA5, crcOkOf(64'hA5, 8), "byteA5");
    waitDrain(1'b1, "byteA5", crcOkOf(64'hA5, 8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
